// File: rtl/filter_ctrl.sv
// filter_ctrl: CPU register block, run sequencer and data-memory arbiter for the
// weighted order-statistics filter engine. Define FILTER_IRQ_EN to build the interrupt.
module filter_ctrl #(
    parameter int unsigned WORD  = 16,
    parameter int unsigned MAX_N = 25,
    parameter int unsigned AW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reg_sel_i,
    input  logic            reg_we_i,
    input  logic [2:0]      reg_addr_i,
    input  logic [31:0]     reg_wdata_i,
    output logic [31:0]     reg_rdata_o,
    input  logic            cpu_mem_req_i,
    input  logic [AW-1:0]   cpu_mem_addr_i,
    input  logic            cpu_mem_we_i,
    output logic            cpu_mem_stall_o,
    output logic [WORD-1:0] eng_h_o,
    output logic [WORD-1:0] eng_w_o,
    output logic [WORD-1:0] eng_n_o,
    output logic            eng_run_o,
    output logic            eng_rst_n_o,
    input  logic            eng_running_i,
    input  logic [AW-1:0]   eng_addr_i,
    input  logic            eng_w_en_i,
    input  logic            eng_r_en_i,
    output logic [AW-1:0]   mem_addr_o,
    output logic            mem_we_o,
    output logic            mem_re_o,
    output logic            irq_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StArm,
        StBusy,
        StFinish
    } state_e;

    localparam logic [2:0] AddrCtrl   = 3'd0;
    localparam logic [2:0] AddrStatus = 3'd1;
    localparam logic [2:0] AddrH      = 3'd2;
    localparam logic [2:0] AddrW      = 3'd3;
    localparam logic [2:0] AddrN      = 3'd4;

    state_e          state_q, state_d;
    logic [WORD-1:0] h_q, w_q, n_q;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      abort_cnt_q, abort_cnt_d;
    logic            irq_en;

    logic wr, wr_ctrl, wr_status;
    logic start_req, abort_req, cfg_valid, busy, eng_owns_port;
    logic start_err, abort_go, done_set;
    logic unused_wdata;

    assign unused_wdata = ^reg_wdata_i;

    assign wr        = reg_sel_i & reg_we_i;
    assign wr_ctrl   = wr && (reg_addr_i == AddrCtrl);
    assign wr_status = wr && (reg_addr_i == AddrStatus);
    assign start_req = wr_ctrl & reg_wdata_i[0];
    assign abort_req = wr_ctrl & reg_wdata_i[2];
    assign busy      = (state_q != StIdle);

    assign cfg_valid = (h_q != '0) && (w_q != '0) && n_q[0] && (32'(n_q) <= MAX_N);

    // Sequencer
    always_comb begin
        state_d   = state_q;
        start_err = 1'b0;
        abort_go  = 1'b0;
        done_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // No launch while the engine is still held in abort reset
                if (start_req && (abort_cnt_q == 2'd0)) begin
                    if (cfg_valid) begin
                        state_d = StLaunch;
                    end else begin
                        start_err = 1'b1;
                    end
                end
            end
            StLaunch: state_d = StArm;
            StArm: begin
                if (eng_running_i) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!eng_running_i) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                done_set = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (abort_req && busy) begin
            state_d  = StIdle;
            abort_go = 1'b1;
            done_set = 1'b0;
        end
    end

    // Status bits: hardware set takes priority over write-1-to-clear
    always_comb begin
        done_d = done_q;
        err_d  = err_q;
        if (wr_status && reg_wdata_i[1]) begin
            done_d = 1'b0;
        end
        if (wr_status && reg_wdata_i[2]) begin
            err_d = 1'b0;
        end
        if (done_set) begin
            done_d = 1'b1;
        end
        if (start_err || abort_go) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        abort_cnt_d = abort_cnt_q;
        if (abort_go) begin
            abort_cnt_d = 2'd2;
        end else if (abort_cnt_q != 2'd0) begin
            abort_cnt_d = abort_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            abort_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            err_q       <= err_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    // Configuration is frozen while a run is in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q <= '0;
            w_q <= '0;
            n_q <= '0;
        end else if (wr && !busy) begin
            if (reg_addr_i == AddrH) h_q <= reg_wdata_i[WORD-1:0];
            if (reg_addr_i == AddrW) w_q <= reg_wdata_i[WORD-1:0];
            if (reg_addr_i == AddrN) n_q <= reg_wdata_i[WORD-1:0];
        end
    end

`ifdef FILTER_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en_q <= reg_wdata_i[1];
            end
            irq_q <= irq_en_q & (done_q | err_q);
        end
    end

    assign irq_en = irq_en_q;
    assign irq_o  = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

    always_comb begin
        reg_rdata_o = '0;
        case (reg_addr_i)
            AddrCtrl:   reg_rdata_o = {29'd0, 1'b0, irq_en, 1'b0};
            AddrStatus: reg_rdata_o = {29'd0, err_q, done_q, busy};
            AddrH:      reg_rdata_o = 32'(h_q);
            AddrW:      reg_rdata_o = 32'(w_q);
            AddrN:      reg_rdata_o = 32'(n_q);
            default:    reg_rdata_o = '0;
        endcase
    end

    assign eng_h_o     = h_q;
    assign eng_w_o     = w_q;
    assign eng_n_o     = n_q;
    assign eng_run_o   = (state_q == StLaunch);
    assign eng_rst_n_o = rst & (abort_cnt_q == 2'd0);

    // Shared data-memory port arbitration
    assign eng_owns_port = (state_q == StArm) || (state_q == StBusy) || (state_q == StFinish);

    always_comb begin
        if (eng_owns_port) begin
            mem_addr_o      = eng_addr_i;
            mem_we_o        = eng_w_en_i;
            mem_re_o        = eng_r_en_i;
            cpu_mem_stall_o = cpu_mem_req_i;
        end else begin
            mem_addr_o      = cpu_mem_addr_i;
            mem_we_o        = cpu_mem_req_i & cpu_mem_we_i;
            mem_re_o        = cpu_mem_req_i & ~cpu_mem_we_i;
            cpu_mem_stall_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_filter_ctrl.sv
// Scoreboard bench for filter_ctrl: directed stimulus queues expectations tagged by cycle,
// a negedge monitor pops and compares them. Honours FILTER_IRQ_EN for irq expectations.
module tb_filter_ctrl;

`ifdef FILTER_IRQ_EN
    localparam bit HasIrq = 1'b1;
`else
    localparam bit HasIrq = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_sel = 1'b0, reg_we = 1'b0;
    logic [2:0]  reg_addr = 3'd0;
    logic [31:0] reg_wdata = 32'd0, reg_rdata;
    logic        cpu_mem_req = 1'b0, cpu_mem_we = 1'b0, cpu_mem_stall;
    logic [31:0] cpu_mem_addr = 32'd0;
    logic [15:0] eng_h, eng_w, eng_n;
    logic        eng_run, eng_rst_n;
    logic        eng_running = 1'b0, eng_w_en = 1'b0, eng_r_en = 1'b0;
    logic [31:0] eng_addr = 32'd0, mem_addr;
    logic        mem_we, mem_re, irq;

    filter_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .reg_sel_i      (reg_sel),
        .reg_we_i       (reg_we),
        .reg_addr_i     (reg_addr),
        .reg_wdata_i    (reg_wdata),
        .reg_rdata_o    (reg_rdata),
        .cpu_mem_req_i  (cpu_mem_req),
        .cpu_mem_addr_i (cpu_mem_addr),
        .cpu_mem_we_i   (cpu_mem_we),
        .cpu_mem_stall_o(cpu_mem_stall),
        .eng_h_o        (eng_h),
        .eng_w_o        (eng_w),
        .eng_n_o        (eng_n),
        .eng_run_o      (eng_run),
        .eng_rst_n_o    (eng_rst_n),
        .eng_running_i  (eng_running),
        .eng_addr_i     (eng_addr),
        .eng_w_en_i     (eng_w_en),
        .eng_r_en_i     (eng_r_en),
        .mem_addr_o     (mem_addr),
        .mem_we_o       (mem_we),
        .mem_re_o       (mem_re),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   run_cnt = 0;
    int   rstlo_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (eng_run) run_cnt <= run_cnt + 1;
    always @(negedge clk) if (rst && !eng_rst_n) rstlo_cnt <= rstlo_cnt + 1;

    // Monitor: compare every expectation queued for the current cycle
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.sel)
                0:       act = reg_rdata;
                1:       act = 32'(eng_run);
                2:       act = 32'(cpu_mem_stall);
                3:       act = 32'(eng_rst_n);
                4:       act = 32'(irq);
                5:       act = 32'(eng_h);
                6:       act = mem_addr;
                7:       act = {30'd0, mem_we, mem_re};
                8:       act = 32'(run_cnt);
                9:       act = 32'(rstlo_cnt);
                default: act = 32'hdead_beef;
            endcase
            checks++;
            if (e.cyc != cyc || act !== e.val) begin
                failures++;
                $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d, queued for %0d)",
                         e.name, act, e.val, cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic s, input logic w, input logic [2:0] a, input logic [31:0] d);
        reg_sel   = s;
        reg_we    = w;
        reg_addr  = a;
        reg_wdata = d;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        drv(1'b1, 1'b1, a, d);
        step();
        drv(1'b0, 1'b0, a, 32'd0);
    endtask

    task automatic chk(input string n, input int s, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.name = n;
        e.sel  = s;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic rd(input string n, input logic [2:0] a, input logic [31:0] v);
        drv(1'b1, 1'b0, a, 32'd0);
        chk(n, 0, v);
    endtask

    initial begin
        // Reset
        step();
        chk("rst_eng_rst_n", 3, 0);
        chk("rst_stall", 2, 0);
        step();
        rst = 1'b1;
        rd("rst_ctrl", 3'd0, 0);
        chk("rst_irq", 4, 0);
        chk("rst_eng_run", 1, 0);
        chk("rst_eng_rst_n_hi", 3, 1);
        step();
        rd("rst_status", 3'd1, 0);
        step();
        rd("rst_h", 3'd2, 0);
        step();
        rd("rst_w", 3'd3, 0);
        step();
        rd("rst_n", 3'd4, 0);
        cpu_mem_req  = 1'b1;
        cpu_mem_we   = 1'b1;
        cpu_mem_addr = 32'h1000;
        chk("idle_cpu_addr", 6, 32'h1000);
        chk("idle_cpu_store", 7, 2'b10);
        chk("idle_no_stall", 2, 0);
        step();

        // Valid run H=8 W=8 N=3
        wr(3'd2, 8);
        wr(3'd3, 8);
        wr(3'd4, 3);
        cpu_mem_we   = 1'b0;
        cpu_mem_addr = 32'h2000;
        drv(1'b1, 1'b1, 3'd0, 32'd3);
        step();
        rd("busy_launch", 3'd1, 1);
        chk("eng_run_pulse", 1, 1);
        chk("stall_launch", 2, 0);
        step();
        eng_running = 1'b1;
        eng_addr    = 32'h0abc;
        eng_w_en    = 1'b1;
        drv(1'b0, 1'b0, 3'd0, 0);
        chk("eng_run_low", 1, 0);
        chk("stall_arm", 2, 1);
        chk("mem_addr_eng", 6, 32'h0abc);
        chk("mem_en_eng", 7, 2'b10);
        step();
        for (int i = 0; i < 200; i++) begin
            if (i == 50) drv(1'b1, 1'b1, 3'd2, 32'd16);
            else if (i == 51) drv(1'b1, 1'b1, 3'd0, 32'd3);
            else rd("status_busy", 3'd1, 1);
            chk("stall_busy", 2, 1);
            step();
        end
        eng_running = 1'b0;
        eng_w_en    = 1'b0;
        rd("h_frozen_reg", 3'd2, 8);
        chk("eng_h_frozen", 5, 8);
        chk("run_once", 8, 1);
        step();
        rd("status_finish", 3'd1, 1);
        chk("stall_finish", 2, 1);
        step();
        rd("status_done", 3'd1, 2);
        chk("stall_released", 2, 0);
        chk("mem_en_cpu", 7, 2'b01);
        chk("mem_addr_cpu", 6, 32'h2000);
        chk("irq_not_yet", 4, 0);
        step();
        drv(1'b1, 1'b1, 3'd1, 32'd2);
        chk("status_before_w1c", 0, 2);
        chk("irq_rise", 4, 32'(HasIrq));
        step();
        rd("status_cleared", 3'd1, 0);
        chk("irq_hold", 4, 32'(HasIrq));
        step();
        rd("ctrl_irq_en", 3'd0, HasIrq ? 32'd2 : 32'd0);
        chk("irq_fall", 4, 0);
        step();

        // Invalid kernel size
        wr(3'd4, 4);
        drv(1'b1, 1'b1, 3'd0, 32'd3);
        step();
        rd("status_err", 3'd1, 4);
        chk("no_run_invalid", 1, 0);
        step();
        drv(1'b1, 1'b1, 3'd1, 32'd4);
        chk("irq_err", 4, 32'(HasIrq));
        chk("run_cnt_invalid", 8, 1);
        step();
        rd("err_cleared", 3'd1, 0);
        step();

        // DONE set wins over simultaneous W1C
        wr(3'd4, 5);
        drv(1'b1, 1'b1, 3'd0, 32'd3);
        step();
        drv(1'b0, 1'b0, 3'd0, 0);
        step();
        eng_running = 1'b1;
        step();
        eng_running = 1'b0;
        step();
        drv(1'b1, 1'b1, 3'd1, 32'd2);
        step();
        rd("done_set_wins", 3'd1, 2);
        step();
        wr(3'd1, 2);

        // Abort during BUSY
        drv(1'b1, 1'b1, 3'd0, 32'd3);
        step();
        drv(1'b0, 1'b0, 3'd0, 0);
        step();
        eng_running = 1'b1;
        step();
        step();
        drv(1'b1, 1'b1, 3'd0, 32'd6);
        chk("stall_pre_abort", 2, 1);
        step();
        eng_running = 1'b0;
        rd("status_abort", 3'd1, 4);
        chk("abort_rst_lo1", 3, 0);
        chk("abort_stall_off", 2, 0);
        step();
        chk("abort_rst_lo2", 3, 0);
        step();
        rd("abort_no_done", 3'd1, 4);
        chk("abort_rst_hi", 3, 1);
        chk("abort_rst_cycles", 9, 2);
        chk("run_cnt_abort", 8, 3);
        step();
        wr(3'd1, 4);

        // Asynchronous reset mid-run
        drv(1'b1, 1'b1, 3'd0, 32'd3);
        step();
        drv(1'b0, 1'b0, 3'd0, 0);
        step();
        eng_running = 1'b1;
        chk("stall_before_rst", 2, 1);
        step();
        rst = 1'b0;
        #1;
        rd("rst_mid_h", 3'd2, 0);
        chk("rst_mid_stall", 2, 0);
        chk("rst_mid_eng_rst", 3, 0);
        chk("rst_mid_irq", 4, 0);
        step();
        rst         = 1'b1;
        eng_running = 1'b0;
        rd("rst_mid_status", 3'd1, 0);
        step();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && sb.size() > 0; i++) step();
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
